wgt_fetch_ctrl: RTL and testbench

//  Upstream feeder for the 4-tap weight shift buffer. Reads signed 8-bit weights from a

---
 rtl/wgt_fetch_ctrl.sv | 110 +++++++++++
 tb/tb_wgt_fetch_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/wgt_fetch_ctrl.sv
// Weight fetch controller: reads 4-weight groups from the weight SRAM, shifts them into
// the tap buffer, holds each group until the PE array consumes it, then fetches the next.
module wgt_fetch_ctrl #(
    parameter int ADDR_W = 10,
    parameter int TAPS   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        num_groups,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              wgt_read,
    output logic [7:0]        wgt_input,
    output logic              grp_valid,
    input  logic              consume,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LAST,
        HOLD,
        FIN
    } state_t;

    localparam logic [1:0] TAP_LAST = 2'(TAPS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        num_q;
    logic [7:0]        grp_cnt;
    logic [1:0]        tap_cnt;
    logic              rd_q;
    logic              last_grp;

    // Widened compare so num_groups = 255 cannot wrap the group counter test.
    assign last_grp = ({1'b0, grp_cnt} + 9'd1) == {1'b0, num_q};

    // NOTE: every output and next-state signal gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        mem_rd_en = 1'b0;
        grp_valid = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:  if (start) state_nxt = (num_groups == 8'd0) ? FIN : FETCH;
            FETCH: begin
                mem_rd_en = 1'b1;
                if (tap_cnt == TAP_LAST) state_nxt = LAST;
            end
            LAST:  state_nxt = HOLD;
            HOLD: begin
                grp_valid = 1'b1;
                if (consume) state_nxt = last_grp ? FIN : FETCH;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    assign mem_addr  = mem_rd_en ? addr : '0;
    assign wgt_read  = rd_q;
    assign wgt_input = rd_q ? mem_rdata : 8'd0;

    // NOTE: asynchronous active-low reset; all state updates use non-blocking assignments
    // so every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr    <= '0;
            num_q   <= 8'd0;
            grp_cnt <= 8'd0;
            tap_cnt <= 2'd0;
            rd_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            rd_q  <= mem_rd_en && !abort;
            if (!abort) begin
                case (state)
                    IDLE: if (start) begin
                        addr    <= base_addr;
                        num_q   <= num_groups;
                        grp_cnt <= 8'd0;
                        tap_cnt <= 2'd0;
                    end
                    FETCH: begin
                        addr    <= addr + 1'b1;
                        tap_cnt <= tap_cnt + 2'd1;
                    end
                    HOLD: if (consume) grp_cnt <= grp_cnt + 8'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wgt_fetch_ctrl.sv
// Self-checking bench for wgt_fetch_ctrl: behavioural SRAM plus a job-level reference
// model (expected address/weight streams and event cycles derived from base and count).
module tb_wgt_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [9:0] base_addr;
    logic [7:0] num_groups;
    logic       mem_rd_en;
    logic [9:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       wgt_read;
    logic [7:0] wgt_input;
    logic       grp_valid;
    logic       consume;
    logic       busy;
    logic       done;

    logic [7:0] mem [1024];
    int         dly_tab [3] = '{0, 3, 7};
    int         n_pass  = 0;
    int         n_total = 0;

    wgt_fetch_ctrl #(.ADDR_W(10), .TAPS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .num_groups(num_groups),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .wgt_read(wgt_read), .wgt_input(wgt_input), .grp_valid(grp_valid),
        .consume(consume), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM: data appears the cycle after the read enable.
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Runs one job to completion and compares it against the reference expectations.
    task automatic run_job(input logic [9:0] base, input int num, input bit fixed);
        int          cyc = 0, ev = 0, hold_start = 0, dly = 0, consumed = 0;
        int          done_cnt = 0, done_cyc = 0, budget, bad = 0, mism = 0;
        bit          in_hold = 0;
        logic [9:0]  aq [$];
        logic [7:0]  wq [$];
        logic [31:0] tap_buf = '0;
        logic [31:0] exp_buf;
        @(negedge clk);
        start = 1'b1; base_addr = base; num_groups = 8'(num);
        @(posedge clk);
        budget = num * 16 + 20;
        while (done_cnt == 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start   = 1'b0;
            consume = 1'b0;
            if (busy !== 1'b1) bad++;
            if (mem_rd_en === 1'b1) aq.push_back(mem_addr);
            if (wgt_read === 1'b1) begin
                wq.push_back(wgt_input);
                tap_buf = {tap_buf[23:0], wgt_input};
            end else if (wgt_input !== 8'd0) bad++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (grp_valid === 1'b1) begin
                if (mem_rd_en !== 1'b0 || wgt_read !== 1'b0) bad++;
                if (!in_hold) begin
                    in_hold    = 1'b1;
                    hold_start = cyc;
                    check("grp_valid latency", cyc, ev + 6);
                    exp_buf = {mem[10'(base + consumed*4)],     mem[10'(base + consumed*4 + 1)],
                               mem[10'(base + consumed*4 + 2)], mem[10'(base + consumed*4 + 3)]};
                    check("buffer taps 3..0", tap_buf, exp_buf);
                    dly = fixed ? dly_tab[consumed % 3] : int'($urandom_range(0, 5));
                end
                if (cyc - hold_start == dly) begin
                    consume  = 1'b1;
                    ev       = cyc;
                    consumed++;
                    in_hold  = 1'b0;
                end
            end
        end
        consume = 1'b0;
        check("done count", done_cnt, 1);
        check("done cycle", done_cyc, ev + 1);
        check("groups consumed", consumed, num);
        check("read count", aq.size(), 4 * num);
        check("strobe count", wq.size(), 4 * num);
        for (int i = 0; i < aq.size() && i < 4 * num; i++)
            if (aq[i] !== 10'(base + i)) mism++;
        for (int i = 0; i < wq.size() && i < 4 * num; i++)
            if (wq[i] !== mem[10'(base + i)]) mism++;
        check("addr/weight stream mismatches", mism, 0);
        check("stray activity", bad, 0);
        @(negedge clk);
        check("idle after done", {busy, done, mem_rd_en, wgt_read, grp_valid}, 5'b0);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; consume = 1'b0;
        base_addr = '0; num_groups = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        for (int k = 0; k < 4; k++) mem[16 + k] = 8'(k + 1);
        #12;
        check("reset outputs", {busy, done, mem_rd_en, wgt_read, grp_valid}, 5'b0);
        check("reset wgt_input", wgt_input, 8'd0);
        @(negedge clk); rst_n = 1'b1;

        // T1: reset mid-FETCH
        @(negedge clk); start = 1'b1; base_addr = 10'h050; num_groups = 8'd2;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("t1 fetching before reset", mem_rd_en, 1'b1);
        rst_n = 1'b0; #1;
        check("t1 outputs in reset", {busy, done, mem_rd_en, wgt_read, grp_valid}, 5'b0);
        check("t1 addr/data in reset", {mem_addr, wgt_input}, 18'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("t1 idle after release", {busy, mem_rd_en}, 2'b0);

        // T2 single group, T3 three groups with 0/3/7 waits, T4 empty job, T5 wrap
        run_job(10'h010, 1, 1'b1);
        run_job(10'h010, 3, 1'b1);
        run_job(10'h123, 0, 1'b0);
        run_job(10'h3FE, 1, 1'b0);

        // T6: abort in the third FETCH cycle with start/consume asserted while busy
        @(negedge clk); start = 1'b1; base_addr = 10'h100; num_groups = 8'd2;
        @(negedge clk); base_addr = 10'h200;
        check("t6 first read addr", mem_addr, 10'h100);
        @(negedge clk); consume = 1'b1;
        check("t6 start ignored while busy", mem_addr, 10'h101);
        @(negedge clk); abort = 1'b1;
        check("t6 third fetch addr", mem_addr, 10'h102);
        @(negedge clk); abort = 1'b0; start = 1'b0; consume = 1'b0;
        check("t6 idle after abort", {busy, done, mem_rd_en, wgt_read, grp_valid}, 5'b0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if ({busy, done, mem_rd_en, wgt_read, grp_valid} !== 5'b0) bad++;
        end
        check("t6 quiet after abort", bad, 0);
        run_job(10'h100, 2, 1'b0);

        // Randomized jobs, then the largest group count
        for (int j = 0; j < 4; j++) run_job(10'($urandom), int'($urandom_range(1, 4)), 1'b0);
        run_job(10'($urandom), 255, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
